// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//   Direct-mapped branch predictor for an in-order pipeline. IF looks up the
//   fetch PC combinationally and gets a taken/target prediction in the same
//   cycle; ID reports resolved branches, which train a per-entry saturating
//   counter and a branch target buffer. A static not-taken mode keeps the
//   table frozen and only runs the statistics.
//
// Parameters
//   ADDR_W  - PC / target width
//   INDEX_W - table depth is 2**INDEX_W entries, indexed by pc[INDEX_W+1:2]
//   CNT_W   - saturating counter width (1..4)
//   MODE    - 0 = static not-taken, 1 = dynamic (counters + BTB)
//
// Ports
//   clk, rst          - clock, synchronous active-high reset
//   if_pc             - PC being fetched
//   pred_taken        - predicted taken for if_pc
//   pred_target       - predicted target (0 when not taken)
//   upd_valid         - a branch resolves this cycle
//   upd_pc            - PC of the resolved branch
//   upd_taken         - actual outcome
//   upd_target        - actual target
//   upd_pred_taken    - prediction that IF made for this branch
//   upd_pred_target   - target that IF predicted for this branch
//   mispredict        - combinational flush request
//   stat_branch_cnt   - resolved branch count (saturating)
//   stat_miss_cnt     - misprediction count (saturating)
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INDEX_W = 6,
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned MODE    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    output logic              mispredict,
    output logic [31:0]       stat_branch_cnt,
    output logic [31:0]       stat_miss_cnt
);

    localparam int unsigned DEPTH = 1 << INDEX_W;
    localparam int unsigned TAG_W = ADDR_W - INDEX_W - 2;
    localparam bit          DYN   = (MODE == 1);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] WEAK_T  = CNT_W'(1 << (CNT_W - 1));
    localparam logic [CNT_W-1:0] WEAK_NT = CNT_W'((1 << (CNT_W - 1)) - 1);

    // Table state
    logic [DEPTH-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q [DEPTH];
    logic [CNT_W-1:0]  cnt_q [DEPTH];
    logic [ADDR_W-1:0] tgt_q [DEPTH];

    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] miss_cnt_q,   miss_cnt_d;

    // Lookup / update decode
    logic [INDEX_W-1:0] lk_idx, upd_idx;
    logic [TAG_W-1:0]   lk_tag, upd_tag;
    logic               lk_hit, upd_hit;
    logic               tbl_we;
    logic [CNT_W-1:0]   cnt_cur, cnt_nxt;

    // Byte-offset bits never participate in index or tag.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{if_pc[1:0], upd_pc[1:0]};

    // Lookup reads registered table state only, so an update to the same
    // entry in the same cycle is seen one cycle later.
    always_comb begin
        lk_idx      = if_pc[INDEX_W+1:2];
        lk_tag      = if_pc[ADDR_W-1:INDEX_W+2];
        lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken  = DYN && lk_hit && cnt_q[lk_idx][CNT_W-1];
        pred_target = pred_taken ? tgt_q[lk_idx] : '0;
    end

    assign mispredict = upd_valid &&
                        ((upd_pred_taken != upd_taken) ||
                         (upd_taken && (upd_pred_target != upd_target)));

    always_comb begin
        upd_idx = upd_pc[INDEX_W+1:2];
        upd_tag = upd_pc[ADDR_W-1:INDEX_W+2];
        upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        cnt_cur = cnt_q[upd_idx];
        cnt_nxt = cnt_cur;
        if (!upd_hit) begin
            cnt_nxt = WEAK_T;
        end else if (upd_taken) begin
            if (cnt_cur != CNT_MAX) cnt_nxt = cnt_cur + CNT_W'(1);
        end else begin
            if (cnt_cur != '0) cnt_nxt = cnt_cur - CNT_W'(1);
        end
        // Not-taken misses leave the table alone.
        tbl_we = DYN && upd_valid && (upd_hit || upd_taken);
    end

    always_comb begin
        branch_cnt_d = branch_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        if (upd_valid && (branch_cnt_q != '1)) branch_cnt_d = branch_cnt_q + 32'd1;
        if (mispredict && (miss_cnt_q != '1))  miss_cnt_d   = miss_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
                cnt_q[i] <= WEAK_NT;
                tgt_q[i] <= '0;
            end
        end else if (tbl_we) begin
            valid_q[upd_idx] <= 1'b1;
            tag_q[upd_idx]   <= upd_tag;
            cnt_q[upd_idx]   <= cnt_nxt;
            if (upd_taken) tgt_q[upd_idx] <= upd_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            branch_cnt_q <= branch_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign stat_branch_cnt = branch_cnt_q;
    assign stat_miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//   Drives one dynamic-mode and one static-mode predictor with identical
//   stimulus. Each cycle's expected outputs are queued when the inputs are
//   driven and compared at the following falling edge.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;

    logic        pt1, pt0, mp1, mp0;
    logic [31:0] tgt1, tgt0, bc1, bc0, mc1, mc0;

    always #5 clk = ~clk;

    branch_predictor #(.ADDR_W(32), .INDEX_W(6), .CNT_W(2), .MODE(1)) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc),
        .pred_taken(pt1), .pred_target(tgt1),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .mispredict(mp1),
        .stat_branch_cnt(bc1), .stat_miss_cnt(mc1)
    );

    branch_predictor #(.ADDR_W(32), .INDEX_W(6), .CNT_W(2), .MODE(0)) dut_static (
        .clk(clk), .rst(rst), .if_pc(if_pc),
        .pred_taken(pt0), .pred_target(tgt0),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .mispredict(mp0),
        .stat_branch_cnt(bc0), .stat_miss_cnt(mc0)
    );

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } sb_t;

    sb_t sb[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  exp_bc   = 0;
    int  exp_mc   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0: return {31'd0, pt1};
            1: return tgt1;
            2: return {31'd0, mp1};
            3: return bc1;
            4: return mc1;
            5: return {31'd0, pt0};
            6: return tgt0;
            7: return {31'd0, mp0};
            8: return bc0;
            default: return mc0;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        sb_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.sel), e.exp);
        end
    endtask

    // One cycle: drive, queue expectations, compare at negedge, clock, then
    // advance the statistics model.
    task automatic cyc(input string name, input logic [31:0] pc,
                       input logic uv, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utgt, input logic upt, input logic [31:0] uptgt,
                       input logic ept, input logic [31:0] etgt, input logic emp);
        if_pc           = pc;
        upd_valid       = uv;
        upd_pc          = upc;
        upd_taken       = ut;
        upd_target      = utgt;
        upd_pred_taken  = upt;
        upd_pred_target = uptgt;
        push({name, ".pt"},   0, {31'd0, ept});
        push({name, ".tgt"},  1, etgt);
        push({name, ".mp"},   2, {31'd0, emp});
        push({name, ".bc"},   3, 32'(exp_bc));
        push({name, ".mc"},   4, 32'(exp_mc));
        push({name, ".s_pt"}, 5, 32'd0);
        push({name, ".s_tgt"},6, 32'd0);
        push({name, ".s_mp"}, 7, {31'd0, emp});
        push({name, ".s_bc"}, 8, 32'(exp_bc));
        push({name, ".s_mc"}, 9, 32'(exp_mc));
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
        if (uv) begin
            exp_bc++;
            if (emp) exp_mc++;
        end
    endtask

    task automatic look(input string name, input logic [31:0] pc,
                        input logic ept, input logic [31:0] etgt);
        cyc(name, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, ept, etgt, 1'b0);
    endtask

    // Reset with an optional update present; the update must be discarded.
    task automatic do_reset(input logic uv, input logic [31:0] upc, input logic [31:0] utgt);
        rst             = 1'b1;
        if_pc           = 32'h0;
        upd_valid       = uv;
        upd_pc          = upc;
        upd_taken       = 1'b1;
        upd_target      = utgt;
        upd_pred_taken  = 1'b0;
        upd_pred_target = 32'h0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        exp_bc = 0;
        exp_mc = 0;
    endtask

    initial begin
        do_reset(1'b0, 32'h0, 32'h0);
        do_reset(1'b0, 32'h0, 32'h0);

        look("rst_lookup", 32'h100, 1'b0, 32'h0);
        // Allocate; same-cycle lookup still sees the empty entry.
        cyc("alloc", 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        look("after_alloc", 32'h100, 1'b1, 32'h200);
        // Three taken updates, counter saturates at 3.
        cyc("tk1", 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0);
        cyc("tk2", 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0);
        cyc("tk3", 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0);
        cyc("nt1", 32'h100, 1'b1, 32'h100, 1'b0, 32'h0,   1'b1, 32'h200, 1'b1, 32'h200, 1'b1);
        cyc("nt2", 32'h100, 1'b1, 32'h100, 1'b0, 32'h0,   1'b1, 32'h200, 1'b1, 32'h200, 1'b1);
        look("after_nt2", 32'h100, 1'b0, 32'h0);
        // Hit with taken retrains and overwrites the target.
        cyc("retarget", 32'h100, 1'b1, 32'h100, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        look("after_retarget", 32'h100, 1'b1, 32'h300);
        // Aliasing on index 0.
        look("alias_lookup", 32'h200, 1'b0, 32'h0);
        cyc("alias_alloc", 32'h200, 1'b1, 32'h200, 1'b1, 32'h400, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        look("evicted", 32'h100, 1'b0, 32'h0);
        look("alias_hit", 32'h200, 1'b1, 32'h400);
        // Not-taken misses leave the table untouched.
        cyc("nt_miss_a", 32'h104, 1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        look("nt_miss_a_chk", 32'h104, 1'b0, 32'h0);
        cyc("nt_miss_b", 32'h200, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h400, 1'b0);
        look("nt_miss_b_chk", 32'h200, 1'b1, 32'h400);
        // Direction right, target wrong.
        cyc("tgt_miss", 32'h200, 1'b1, 32'h200, 1'b1, 32'h400, 1'b1, 32'h500, 1'b1, 32'h400, 1'b1);
        // upd_* ignored without upd_valid.
        cyc("no_valid", 32'h200, 1'b0, 32'h200, 1'b1, 32'h999, 1'b0, 32'h0, 1'b1, 32'h400, 1'b0);
        look("no_valid_chk", 32'h200, 1'b1, 32'h400);
        // Reset wins over a simultaneous update.
        do_reset(1'b1, 32'h104, 32'h600);
        look("rst_prio_a", 32'h104, 1'b0, 32'h0);
        look("rst_prio_b", 32'h200, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
